// File: rtl/dcache_direct.sv
// dcache_direct: direct-mapped, write-back, write-allocate data cache with a
// 4-word line, combinational hits and a mem_ready-handshaked 128-bit refill bus.
// Optional feature macro: DCACHE_STATS_EN adds hit_cnt / miss_cnt counters.
module dcache_direct #(
    parameter int unsigned NUM_SETS = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [31:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic [31:0]  proc_rdata,
    output logic         proc_stall,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]  hit_cnt,
    output logic [31:0]  miss_cnt
`endif
);
    localparam int unsigned IDX_W = $clog2(NUM_SETS);
    localparam int unsigned TAG_W = 28 - IDX_W;

    typedef enum logic [1:0] {IDLE, WBACK, ALLOC} state_t;

    state_t              state;
    state_t              state_next;

    logic [NUM_SETS-1:0] valid_q;
    logic [NUM_SETS-1:0] dirty_q;
    logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
    logic [127:0]        data_mem [NUM_SETS];

    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    tag;
    logic [1:0]          word_sel;
    logic [127:0]        cur_line;
    logic                req;
    logic                hit;
    logic                miss;
    logic                refill_done_now;
    logic                unused_byte_bits;

    logic                mem_read_d;
    logic                mem_write_d;
    logic [27:0]         mem_addr_d;
    logic [127:0]        mem_wdata_d;

    assign idx              = proc_addr[4 +: IDX_W];
    assign tag              = proc_addr[31 -: TAG_W];
    assign word_sel         = proc_addr[3:2];
    assign unused_byte_bits = ^proc_addr[1:0];
    assign cur_line         = data_mem[idx];
    assign req              = proc_read | proc_write;
    assign hit              = (state == IDLE) && req && valid_q[idx] && (tag_mem[idx] == tag);
    assign refill_done_now  = (state == ALLOC) && mem_ready;

    // Next-state, stall/read-data outputs and next values of the memory-side request registers.
    always_comb begin
        state_next  = state;
        proc_stall  = 1'b0;
        proc_rdata  = '0;
        miss        = 1'b0;
        mem_read_d  = mem_read;
        mem_write_d = mem_write;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        case (state)
            IDLE: begin
                if (hit) begin
                    if (proc_read && !proc_write) begin
                        proc_rdata = cur_line[32*word_sel +: 32];
                    end
                end else if (req) begin
                    proc_stall = 1'b1;
                    miss       = 1'b1;
                    if (valid_q[idx] && dirty_q[idx]) begin
                        state_next  = WBACK;
                        mem_write_d = 1'b1;
                        mem_addr_d  = {tag_mem[idx], idx};
                        mem_wdata_d = cur_line;
                    end else begin
                        state_next  = ALLOC;
                        mem_read_d  = 1'b1;
                        mem_addr_d  = proc_addr[31:4];
                    end
                end
            end
            WBACK: begin
                proc_stall = 1'b1;
                if (mem_ready) begin
                    // Refill request replaces the write-back on the same edge.
                    state_next  = ALLOC;
                    mem_write_d = 1'b0;
                    mem_read_d  = 1'b1;
                    mem_addr_d  = proc_addr[31:4];
                    mem_wdata_d = '0;
                end
            end
            ALLOC: begin
                proc_stall = 1'b1;
                if (mem_ready) begin
                    state_next = IDLE;
                    mem_read_d = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register and registered memory request outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_next;
            mem_read  <= mem_read_d;
            mem_write <= mem_write_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
        end
    end

    // Line status: a store hit dirties the line, a completed refill installs it clean.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (hit && proc_write) begin
            dirty_q[idx] <= 1'b1;
        end else if (refill_done_now) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end
    end

    // Tag and data storage (not reset): refill replaces the line, a store hit merges one word.
    always_ff @(posedge clk) begin
        if (refill_done_now) begin
            data_mem[idx] <= mem_rdata;
            tag_mem[idx]  <= tag;
        end else if (hit && proc_write) begin
            data_mem[idx][32*word_sel +: 32] <= proc_wdata;
        end
    end

`ifdef DCACHE_STATS_EN
    logic refill_done_q;

    // Access statistics; the hit that completes a refilled access is not counted as a hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt       <= '0;
            miss_cnt      <= '0;
            refill_done_q <= 1'b0;
        end else begin
            refill_done_q <= refill_done_now;
            if (miss) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
            if (hit && !refill_done_q) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/dcache_direct.md
# dcache_direct

Direct-mapped, write-back, write-allocate data cache between the pipeline's MEM-stage memory port and slow main memory. Hits are answered combinationally with no stall. Misses stall the pipeline while a 4-word line is optionally written back and then refilled over a 128-bit memory bus with a `mem_ready` handshake.

## Interface
- `NUM_SETS`, default 8: number of lines; power of two, ≥2. `IDX_W` = log2(`NUM_SETS`).
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `proc_read` in 1: pipeline load request; held until `proc_stall` is low.
- `proc_write` in 1: pipeline store request; held until `proc_stall` is low.
- `proc_addr` in 32: byte address. Bits [1:0] are ignored, [3:2] select the word, [4+IDX_W-1:4] are the index, and the rest is the tag.
- `proc_wdata` in 32: store data.
- `proc_rdata` out 32: load data; valid while `proc_read` is high and `proc_stall` is low.
- `proc_stall` out 1: freezes the pipeline.
- `mem_read` out 1: line refill request.
- `mem_write` out 1: line write-back request.
- `mem_addr` out 28: line address (byte address >> 4).
- `mem_wdata` out 128: victim line; word 0 is in [31:0].
- `mem_rdata` in 128: refill line, same packing; sampled when `mem_ready` is high.
- `mem_ready` in 1: one-cycle pulse that completes the outstanding request.

## Operation
- Storage per line: valid bit, dirty bit, tag, 4×32 data.
- States: `IDLE`, `WBACK`, `ALLOC`.
- `IDLE`, no request: `proc_stall`=0.
- `IDLE`, hit (valid and tag match):
  - `proc_stall`=0.
  - Read: `proc_rdata` = the selected word.
  - Write: the word is updated and dirty is set at the clock edge.
- `IDLE`, miss: `proc_stall`=1 in the same cycle.
  - Victim valid and dirty: go to `WBACK`.
  - Otherwise: go to `ALLOC`.
- `WBACK`:
  - Outputs: `mem_write`=1, `mem_addr`={victim tag, index}, `mem_wdata`=victim line, `proc_stall`=1.
  - On `mem_ready`: go to `ALLOC`.
- `ALLOC`:
  - Outputs: `mem_read`=1, `mem_addr`=`proc_addr`[31:4], `proc_stall`=1.
  - On `mem_ready`: load `mem_rdata`, set valid=1, dirty=0, write the new tag, and return to `IDLE`.
  - The access then hits in the next cycle. A store merges and sets dirty at that point.
- `proc_read` and `proc_write` both high: treated as a write; `proc_rdata` is don't-care.
- `proc_rdata` is 0 whenever no read hit is being served.
- Address bits above the tag range are not truncated: the tag width is 28-`IDX_W`.

## Timing
- Reset values: all valid=0 and dirty=0; state `IDLE`; `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0, `proc_stall`=0, `proc_rdata`=0. Data and tag arrays are not reset.
- Hit latency: 0 cycles; the result is available in the request cycle.
- Clean miss: `proc_stall` is high for L+1 cycles, where L is the cycle count from `mem_read` assertion to `mem_ready` inclusive.
- Dirty miss: `proc_stall` is high for Lw+Lr+1 cycles.
- Memory requests:
  - `mem_read` and `mem_write` are registered and never both high.
  - A request is held stable until the cycle of `mem_ready`, and drops the cycle after.
  - `WBACK`→`ALLOC` inserts no idle cycle; `mem_write` falls and `mem_read` rises on the same edge.
- `mem_ready` in `IDLE` is ignored.
- `rst` mid-refill or mid-write-back aborts the transfer: outputs return to reset values on the next edge. Memory must tolerate the dropped request.
- Request inputs are assumed stable while stalled. A change of `proc_addr` during stall has undefined effect.

## Configuration
- `DCACHE_STATS_EN` defined:
  - Adds outputs `hit_cnt` out 32 and `miss_cnt` out 32, both reset to 0.
  - `miss_cnt` increments once per miss, on the `IDLE`→`WBACK`/`ALLOC` edge.
  - `hit_cnt` increments once per hit in `IDLE`, except the completing hit after a refill.
  - Both counters wrap at 2^32.
- `DCACHE_STATS_EN` undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset, then read 0x0000_0040 with memory returning line {4,3,2,1} after 3 cycles → `mem_read` with `mem_addr`=0x000_0004 for 3 cycles, `proc_stall` high for 4 cycles, then `proc_rdata`=1. A read of 0x0000_004C is then a 0-stall hit returning 4.
- Write 0xDEAD_BEEF to 0x0000_0044 (hit), then read 0x0000_00C4 (same index 4, other tag) → `mem_write` with `mem_addr`=0x000_0004 and `mem_wdata`[63:32]=0xDEAD_BEEF, then `mem_read` with `mem_addr`=0x000_000C on the very next cycle.
- Write miss to 0x0000_0100 with data 0x1234_5678 → clean refill only. A later eviction writes back word 0 = 0x1234_5678.
- Assert `rst` while `ALLOC` is waiting → the next cycle has `mem_read`=0 and `proc_stall`=0. Re-reading the same address misses again.
- Assert `proc_read` and `proc_write` together on a hit → the store is performed and dirty is set.
- With `DCACHE_STATS_EN`: 1 miss followed by 3 hits gives `miss_cnt`=1 and `hit_cnt`=3.
